// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, ALU select codes and the operand bundle type.
package alu_arbiter_pkg;

   localparam int DATA_W = 8;
   localparam int SEL_W  = 3;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [SEL_W-1:0]  sel_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam sel_t SEL_FWD = 3'b000;
   localparam sel_t SEL_ADD = 3'b001;
   localparam sel_t SEL_AND = 3'b010;
   localparam sel_t SEL_OR  = 3'b011;

   // One requester's operation, as loaded into the ALU drive registers at grant.
   typedef struct packed {
      data_t data1;
      data_t data2;
      sel_t  select;
   } op_t;

   // Down-counter preload for the EXEC phase; legal latencies 1..4 fit in 2 bits.
   function automatic logic [1:0] exec_load(input int latency);
      return 2'(latency - 1);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, return-bus and shared-ALU signals of the ALU arbiter.
// master = requesters plus external ALU, slave = the arbiter itself.
interface alu_arbiter_if;
   import alu_arbiter_pkg::*;

   logic  req0;
   logic  req1;
   data_t op0_data1;
   data_t op0_data2;
   sel_t  op0_select;
   data_t op1_data1;
   data_t op1_data2;
   sel_t  op1_select;

   logic  ack0;
   logic  ack1;
   data_t result;
   logic  zero;
   logic  busy;

   data_t alu_data1;
   data_t alu_data2;
   sel_t  alu_select;
   data_t alu_result;
   logic  alu_zero;

   modport master (
      output req0, req1,
      output op0_data1, op0_data2, op0_select,
      output op1_data1, op1_data2, op1_select,
      output alu_result, alu_zero,
      input  ack0, ack1, result, zero, busy,
      input  alu_data1, alu_data2, alu_select
   );

   modport slave (
      input  req0, req1,
      input  op0_data1, op0_data2, op0_select,
      input  op1_data1, op1_data2, op1_select,
      input  alu_result, alu_zero,
      output ack0, ack1, result, zero, busy,
      output alu_data1, alu_data2, alu_select
   );

endinterface

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way grant picker: a lone request wins, a tie goes to the requester
// not granted last. With ALU_ARB_FIXED_PRIO_EN the caller ties last_grant high.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_id
);

   // NOTE: every output is assigned before any branch so no latch is inferred.
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = req1;
      if (req0 && req1) begin
         gnt_id = ~last_grant;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU: IDLE -> EXEC -> DONE FSM.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int ALU_LATENCY = 1
) (
   input logic         clk,
   input logic         reset,
   alu_arbiter_if.slave bus
);

   localparam logic [1:0] CNT_LOAD = exec_load(ALU_LATENCY);

   state_t     state;
   logic [1:0] cnt;
   logic       grant_id;
   logic       last_grant;
   logic       pick_valid;
   logic       pick_id;
   op_t        op_pick;

   logic       ack0_q;
   logic       ack1_q;
   logic       busy_q;
   data_t      result_q;
   logic       zero_q;
   op_t        alu_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Constant "1 granted last" makes requester 0 win every tie.
   assign last_grant = 1'b1;
`endif

   rr_pick2 u_pick (
      .req0       (bus.req0),
      .req1       (bus.req1),
      .last_grant (last_grant),
      .gnt_valid  (pick_valid),
      .gnt_id     (pick_id)
   );

   always_comb begin
      op_pick = pick_id ? {bus.op1_data1, bus.op1_data2, bus.op1_select}
                        : {bus.op0_data1, bus.op0_data2, bus.op0_select};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         grant_id <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         alu_q    <= '{data1: '0, data2: '0, select: SEL_FWD};
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= EXEC;
                  busy_q   <= 1'b1;
                  cnt      <= CNT_LOAD;
                  grant_id <= pick_id;
                  alu_q    <= op_pick;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last_grant <= pick_id;
`endif
               end
            end
            EXEC: begin
               // Requests are ignored here; the in-flight operation always completes.
               if (cnt == 2'd0) begin
                  state    <= DONE;
                  result_q <= bus.alu_result;
                  zero_q   <= bus.alu_zero;
                  ack0_q   <= ~grant_id;
                  ack1_q   <= grant_id;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack0       = ack0_q;
   assign bus.ack1       = ack1_q;
   assign bus.busy       = busy_q;
   assign bus.result     = result_q;
   assign bus.zero       = zero_q;
   assign bus.alu_data1  = alu_q.data1;
   assign bus.alu_data2  = alu_q.data2;
   assign bus.alu_select = alu_q.select;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LATENCY, default 1, meaning the number of EXEC cycles spent waiting for the ALU to settle (legal range 1..4).
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 RESET  in  1  reset, synchronous and active-high.
REQ-004 REQ0, REQ1  in  1 each  operation request from requester 0 / 1, held high until the matching ACK.
REQ-005 OP0_DATA1, OP0_DATA2, OP1_DATA1, OP1_DATA2  in  8 each  operands of requester 0 / 1.
REQ-006 OP0_SELECT, OP1_SELECT  in  3 each  ALU function code of requester 0 / 1.
REQ-007 ACK0, ACK1  out  1 each  one-cycle completion pulse for requester 0 / 1.
REQ-008 RESULT  out  8, ZERO  out  1  shared return bus; valid only while ACK0 or ACK1 is high.
REQ-009 BUSY  out  1  high whenever the state is not IDLE.
REQ-010 ALU_DATA1, ALU_DATA2  out  8 each, ALU_SELECT  out  3  registered drive to the shared ALU.
REQ-011 ALU_RESULT  in  8, ALU_ZERO  in  1  outputs returned from the shared ALU.

Function
REQ-012 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-013 In IDLE with any REQ high, one requester SHALL be granted at the clock edge: its OPx_DATA1, OPx_DATA2 and OPx_SELECT load into ALU_DATA1, ALU_DATA2 and ALU_SELECT, a grant-ID register is set, and the state moves to EXEC.
REQ-014 EXEC SHALL last exactly ALU_LATENCY cycles, counted by a down-counter loaded with ALU_LATENCY-1 at grant.
REQ-015 At the edge ending the last EXEC cycle, ALU_RESULT and ALU_ZERO SHALL be captured into RESULT and ZERO, and the state SHALL move to DONE.
REQ-016 In DONE, the ACK of the granted requester SHALL be high for exactly one cycle; the state then returns to IDLE.
REQ-017 Latency: a request sampled in cycle N SHALL produce its ACK in cycle N+1+ALU_LATENCY; peak throughput is one operation per ALU_LATENCY+2 cycles.
REQ-018 Operands SHALL be sampled only at grant; OPx changes after grant do not affect the operation in flight.
REQ-019 REQx deasserted while its operation is in EXEC SHALL NOT abort the operation; the ACK is still pulsed.
REQ-020 REQx still high in IDLE after its ACK SHALL be treated as a new request.
REQ-021 REQ inputs SHALL be ignored while in EXEC or DONE.
REQ-022 Round-robin arbitration: when both REQ are high in IDLE, the requester not granted last SHALL win; a lone request always wins.
REQ-023 ALU_DATA1, ALU_DATA2 and ALU_SELECT SHALL hold their last values between operations.
REQ-024 SELECT codes SHALL pass through unchecked; codes 100..111 give whatever the ALU mux produces.
REQ-025 RESULT and ZERO SHALL hold their last captured values outside DONE.
REQ-026 ACK0 and ACK1 SHALL never be high together.

Reset
REQ-027 RESET high at a clock edge SHALL force: state IDLE, ACK0=ACK1=0, BUSY=0, RESULT=0, ZERO=0, ALU_DATA1=ALU_DATA2=0, ALU_SELECT=000, counter 0, last-grant=1 (requester 0 wins the first tie).
REQ-028 RESET during EXEC or DONE SHALL abandon the operation; no ACK is issued for it.
REQ-029 RESET SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 With macro ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win a tie and the last-grant register SHALL be omitted.
REQ-031 Without ALU_ARB_FIXED_PRIO_EN, the arbitration SHALL be round-robin per REQ-022.

Structure
REQ-032 The shared package SHALL hold: the state encodings (IDLE=2'b00, EXEC=2'b01, DONE=2'b10), the ALU select codes (FWD=000, ADD=001, AND=010, OR=011) and the 8-bit data width constant.
REQ-033 A single combinational sub-module, rr_pick2, SHALL compute the grant from REQ0, REQ1 and last-grant; the FSM, counter and registers stay in alu_arbiter.

Verification
REQ-034 Single ADD: REQ0 with OP0 = 0x05, 0x03, select 001 (ALU_LATENCY=1), request sampled in cycle N -> ACK0 in cycle N+2, RESULT=0x08, ZERO=0, ACK1 low throughout.
REQ-035 Tie: REQ0 and REQ1 both held from reset, REQ1 = AND of 0xF0 and 0x0F -> grant order 0,1,0,1; requester 1 results show RESULT=0x00, ZERO=1; with ALU_ARB_FIXED_PRIO_EN the order is 0,0,0.
REQ-036 Operand change: OP1_DATA2 changed from 0x01 to 0x7F during EXEC on a FWD operation -> RESULT=0x01.
REQ-037 Reset mid-operation: RESET pulsed during EXEC of an OR -> no ACK, all outputs at reset values, the next request completes normally.
REQ-038 Latency parameter: ALU_LATENCY=4, OR of 0xA0 and 0x05 sampled in cycle N -> BUSY high in cycles N+1..N+5, ACK in cycle N+5, RESULT=0xA5.
